pnr_polarity_detect: RTL and testbench

- Calibration block in the PNR front end that determines the pulse polarity of the 14-bit ADC stream.
- Produces the inversion control consumed by the signal-inverse stage.
- On a start request it observes a fixed window of samples and tracks min, max and mean.
- It then decides whether pulses swing above or below the baseline, and holds the result until the next calibration.

---
 rtl/pnr_polarity_detect.sv | 146 ++++++++++++++
 tb/tb_pnr_polarity_detect.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnr_polarity_detect.sv
// Pulse-polarity calibration for the PNR 14-bit ADC stream.
// Observes 2^WIN_LOG2 samples, then decides whether pulses swing above or below the mean.
module pnr_polarity_detect #(
  parameter int unsigned DW        = 14,
  parameter int unsigned WIN_LOG2  = 16,
  parameter int unsigned MIN_SWING = 200
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic signed [DW-1:0] adc_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 valid_o,
  output logic                 fail_o,
  output logic                 is_inverse_o,
  output logic signed [DW-1:0] max_o,
  output logic signed [DW-1:0] min_o
);

  localparam int unsigned AW = DW + WIN_LOG2;
  localparam int unsigned CW = WIN_LOG2;
  localparam logic signed [DW-1:0] SMIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   MIN_SPAN = (DW+1)'(MIN_SWING);
  localparam logic [CW-1:0]        CNT_LAST = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DECIDE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  run_max_q, run_max_d;
  logic signed [DW-1:0]  run_min_q, run_min_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  fail_q, fail_d;
  logic                  inv_q, inv_d;
  logic signed [DW-1:0]  max_q, max_d;
  logic signed [DW-1:0]  min_q, min_d;

  // Window statistics; DW+1 bits so rail-to-rail spans cannot wrap
  logic signed [DW-1:0]  mean;
  logic signed [DW:0]    up;
  logic signed [DW:0]    down;
  logic signed [DW:0]    span;

  assign mean = DW'(acc_q >>> WIN_LOG2);
  assign up   = (DW+1)'(run_max_q) - (DW+1)'(mean);
  assign down = (DW+1)'(mean) - (DW+1)'(run_min_q);
  assign span = (DW+1)'(run_max_q) - (DW+1)'(run_min_q);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
      inv_q     <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      fail_q    <= fail_d;
      inv_q     <= inv_d;
      max_q     <= max_d;
      min_q     <= min_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    fail_d    = fail_q;
    inv_d     = inv_q;
    max_d     = max_q;
    min_d     = min_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          run_max_d = SMIN;
          run_min_d = SMAX;
        end
      end

      ST_RUN: begin
        acc_d = acc_q + AW'(adc_i);
        if (adc_i > run_max_q) run_max_d = adc_i;
        if (adc_i < run_min_q) run_min_d = adc_i;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DECIDE;
      end

      ST_DECIDE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        max_d   = run_max_q;
        min_d   = run_min_q;
        // Too little swing: flag it but keep the previously held polarity
        if (span < MIN_SPAN) begin
          fail_d = 1'b1;
        end else begin
          fail_d  = 1'b0;
          valid_d = 1'b1;
          inv_d   = (down > up);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign valid_o      = valid_q;
  assign fail_o       = fail_q;
  assign is_inverse_o = inv_q;
  assign max_o        = max_q;
  assign min_o        = min_q;

endmodule

// File: tb/tb_pnr_polarity_detect.sv
// Randomized self-checking bench for pnr_polarity_detect (16-sample window).
module tb_pnr_polarity_detect;

  localparam int DW  = 14;
  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic                 clk;
  logic                 rstn_i;
  logic                 start_i;
  logic signed [DW-1:0] adc_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 valid_o;
  logic                 fail_o;
  logic                 is_inverse_o;
  logic signed [DW-1:0] max_o;
  logic signed [DW-1:0] min_o;

  int n_checks;
  int n_pass;
  int cyc;

  // Reference expectations
  bit exp_valid, exp_fail, exp_inv;
  int exp_max, exp_min;

  pnr_polarity_detect #(.DW(14), .WIN_LOG2(4), .MIN_SWING(200)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .adc_i       (adc_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .valid_o     (valid_o),
    .fail_o      (fail_o),
    .is_inverse_o(is_inverse_o),
    .max_o       (max_o),
    .min_o       (min_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Polarity decision from plain arithmetic over the whole window
  function automatic void model(input int s[16]);
    int sum, mx, mn, mean;
    sum = 0; mx = -8192; mn = 8191;
    for (int i = 0; i < W; i++) begin
      sum += s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    mean = (sum >= 0) ? sum / W : -((-sum + W - 1) / W);
    exp_max = mx;
    exp_min = mn;
    if (mx - mn < 200) begin
      exp_fail = 1'b1;
    end else begin
      exp_fail  = 1'b0;
      exp_valid = 1'b1;
      exp_inv   = (mean - mn) > (mx - mean);
    end
  endfunction

  function automatic logic [3+2*DW-1:0] exp_vec();
    return {exp_valid, exp_fail, exp_inv, DW'(exp_max), DW'(exp_min)};
  endfunction

  function automatic int clip(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  // Starts a calibration from a negedge in IDLE; returns at the negedge where done_o is seen
  task automatic run_cal(input int s[16], input bit hold, input int poke,
                         output int lat, output int busy_cnt);
    start_i = 1'b1;
    adc_i   = DW'($urandom);
    @(posedge clk);
    @(negedge clk);
    lat = -1;
    busy_cnt = 0;
    for (int c = 0; c <= 40 && lat < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (busy_o) busy_cnt++;
      if (done_o) lat = c;
      start_i = hold || (c == poke);
      if (c < W) adc_i = DW'(s[c]);
      else       adc_i = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o} !== '0)
      $display("FAIL reset_hold: got busy=%0b done=%0b valid=%0b fail=%0b inv=%0b max=%0d min=%0d, want all 0",
               busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o);
    else n_pass++;
    rstn_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o} !== '0)
      $display("FAIL reset_idle: got busy=%0b done=%0b valid=%0b fail=%0b inv=%0b max=%0d min=%0d, want all 0",
               busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o);
    else n_pass++;
  endtask

  task automatic check_cal(input string name, input int s[16], input bit hold, input int poke);
    int lat, bc;
    model(s);
    run_cal(s, hold, poke, lat, bc);
    n_checks++;
    if (lat !== LAT) $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
    else n_pass++;
    n_checks++;
    if (bc !== LAT) $display("FAIL %s_busy_width: got %0d want %0d", name, bc, LAT);
    else n_pass++;
    n_checks++;
    if ({valid_o, fail_o, is_inverse_o, max_o, min_o} !== exp_vec())
      $display("FAIL %s_result: got valid=%0b fail=%0b inv=%0b max=%0d min=%0d, want valid=%0b fail=%0b inv=%0b max=%0d min=%0d",
               name, valid_o, fail_o, is_inverse_o, max_o, min_o,
               exp_valid, exp_fail, exp_inv, exp_max, exp_min);
    else n_pass++;
  endtask

  task automatic test_positive();
    int s[16];
    for (int i = 0; i < W; i++) s[i] = (i == W - 1) ? 1000 : 0;
    check_cal("positive", s, 1'b0, -1);
  endtask

  task automatic test_negative();
    int s[16];
    for (int i = 0; i < W; i++) s[i] = (i == W - 1) ? -900 : 100;
    check_cal("negative", s, 1'b0, -1);
  endtask

  task automatic test_low_swing();
    int s[16];
    for (int i = 0; i < W; i++) s[i] = int'($urandom_range(100)) - 50;
    check_cal("low_swing", s, 1'b0, -1);
  endtask

  task automatic test_rails();
    int s[16];
    for (int i = 0; i < W; i++) s[i] = (i % 2 == 0) ? 8191 : -8192;
    check_cal("rails", s, 1'b0, -1);
  endtask

  task automatic test_start_during_busy();
    int s[16];
    int extra_done, extra_busy;
    for (int i = 0; i < W; i++) s[i] = int'($urandom_range(4000)) - 2000;
    check_cal("poke", s, 1'b0, 5);
    extra_done = 0;
    extra_busy = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_o) extra_done++;
      if (busy_o) extra_busy++;
    end
    n_checks++;
    if (extra_done + extra_busy !== 0)
      $display("FAIL poke_queued: got extra done=%0d busy=%0d want 0", extra_done, extra_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a[16], b[16];
    int t0, t1;
    for (int i = 0; i < W; i++) begin
      a[i] = (i == 3) ? 3000 : int'($urandom_range(60));
      b[i] = (i == 9) ? -3000 : int'($urandom_range(60));
    end
    check_cal("b2b_first", a, 1'b1, -1);
    t0 = cyc;
    check_cal("b2b_second", b, 1'b0, -1);
    t1 = cyc;
    n_checks++;
    if (t1 - t0 !== LAT + 1) $display("FAIL b2b_spacing: got %0d want %0d", t1 - t0, LAT + 1);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int s[16];
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      adc_i = (c % 2 == 0) ? DW'(8000) : DW'(-8000);
      @(posedge clk);
      @(negedge clk);
    end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o} !== '0)
      $display("FAIL async_reset: got busy=%0b done=%0b valid=%0b fail=%0b inv=%0b max=%0d min=%0d, want all 0",
               busy_o, done_o, valid_o, fail_o, is_inverse_o, max_o, min_o);
    else n_pass++;
    exp_valid = 0; exp_fail = 0; exp_inv = 0; exp_max = 0; exp_min = 0;
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < W; i++) s[i] = (i == 7) ? -500 : 20 + int'($urandom_range(10));
    check_cal("post_reset", s, 1'b0, -1);
  endtask

  task automatic test_random();
    int s[16];
    int base, amp, noise, npk;
    for (int it = 0; it < 6; it++) begin
      base  = int'($urandom_range(4000)) - 2000;
      amp   = int'($urandom_range(6000)) - 3000;
      noise = int'($urandom_range(150));
      npk   = 1 + int'($urandom_range(3));
      for (int i = 0; i < W; i++) begin
        s[i] = base + int'($urandom_range(noise)) - noise / 2;
        if (i < npk) s[i] += amp;
        s[i] = clip(s[i]);
      end
      check_cal($sformatf("random%0d", it), s, 1'b0, -1);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    exp_valid = 0; exp_fail = 0; exp_inv = 0; exp_max = 0; exp_min = 0;
    rstn_i  = 1'b0;
    start_i = 1'b0;
    adc_i   = '0;
    test_reset();
    test_positive();
    test_negative();
    test_low_swing();
    test_rails();
    test_start_during_busy();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
